// File: rtl/note_judge_pkg.sv
// rtl/note_judge_pkg.sv - shared judge codes, FSM states and lane encoding for the hit judge
package note_judge_pkg;

  // Grade reported on judge; J_NONE whenever judge_valid is low
  typedef enum logic [1:0] {
    J_NONE    = 2'd0,
    J_PERFECT = 2'd1,
    J_GOOD    = 2'd2,
    J_MISS    = 2'd3
  } judge_e;

  // WAIT: no judgeable note, ARMED: note awaiting a press, DONE: note already judged
  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Lane code 0 marks a rest; lane k maps to key[k-1]
  localparam int unsigned LANE_REST = 0;

endpackage

// File: rtl/note_judge_key_edge.sv
// rtl/note_judge_key_edge.sv - registered rising-edge detector across all key lanes
module note_judge_key_edge #(
  parameter int LANES = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [LANES-1:0] key_i,
  output logic [LANES-1:0] press_o
);

  logic [LANES-1:0] key_q;

  // Key history; reset loads the live level so a key held through reset never looks like a press
  always_ff @(posedge clk_i) begin
    key_q <= key_i;
  end

  assign press_o = reset_i ? '0 : (key_i & ~key_q);

endmodule

// File: rtl/note_judge.sv
// rtl/note_judge.sv - multi-lane hit judge grading notes and keeping score/combo counters
module note_judge
  import note_judge_pkg::*;
#(
  parameter int LANES       = 3,
  parameter int XW          = 9,
  parameter int PERFECT_EPS = 4,
  parameter int GOOD_EPS    = 10,
  parameter int PTS_PERFECT = 3,
  parameter int PTS_GOOD    = 1,
  parameter int SW          = 8,
  parameter int LW          = $clog2(LANES + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [LANES-1:0] key,
  input  logic             note_valid,
  input  logic [LW-1:0]    note_lane,
  input  logic [XW-1:0]    note_x,
  input  logic             note_advance,
  output logic             judge_valid,
  output logic [1:0]       judge,
  output logic             hit,
  output logic             consume,
  output logic [SW-1:0]    score,
  output logic [SW-1:0]    combo,
  output logic [SW-1:0]    max_combo
);

  localparam logic [XW-1:0] PERFECT_X = XW'(PERFECT_EPS);
  localparam logic [XW-1:0] GOOD_X    = XW'(GOOD_EPS);
  localparam logic [SW:0]   PTS_P     = (SW + 1)'(PTS_PERFECT);
  localparam logic [SW:0]   PTS_G     = (SW + 1)'(PTS_GOOD);

  state_e          state_q;
  judge_e          judge_q;
  logic            judge_valid_q;
  logic            hit_q;
  logic            consume_q;
  logic [SW-1:0]   score_q;
  logic [SW-1:0]   combo_q;
  logic [SW-1:0]   max_combo_q;

  logic [LANES-1:0] press;
  logic [LANES-1:0] lane_mask;
  logic             wrong_press;
  logic             any_press;
  judge_e           press_grade;
  logic [SW:0]      score_sum;
  logic [SW-1:0]    score_d;
  logic [SW-1:0]    combo_d;
  logic [SW-1:0]    max_combo_d;

  note_judge_key_edge #(
    .LANES (LANES)
  ) u_key_edge (
    .clk_i   (CLOCK_50),
    .reset_i (reset),
    .key_i   (key),
    .press_o (press)
  );

  // One-hot key mask of the lane the note asks for; rests and out-of-range codes give no correct key
  always_comb begin
    lane_mask = '0;
    for (int k = 1; k <= LANES; k++) begin
      if (note_lane == LW'(k)) begin
        lane_mask[k-1] = 1'b1;
      end
    end
  end

  assign any_press   = |press;
  assign wrong_press = |(press & ~lane_mask);

  // Grade of this cycle's presses; wrong keys win over the correct one so mashing never scores
  always_comb begin
    press_grade = J_NONE;
    if (any_press && (note_x <= GOOD_X)) begin
      if (wrong_press) begin
        press_grade = J_MISS;
      end else if (note_x <= PERFECT_X) begin
        press_grade = J_PERFECT;
      end else begin
        press_grade = J_GOOD;
      end
    end
  end

  // Saturating counter values that a successful hit would produce
  always_comb begin
    score_sum   = {1'b0, score_q} + ((press_grade == J_PERFECT) ? PTS_P : PTS_G);
    score_d     = score_sum[SW] ? '1 : score_sum[SW-1:0];
    combo_d     = (&combo_q) ? combo_q : combo_q + SW'(1);
    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
  end

  // Note FSM with registered judgement pulses and counter updates
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= S_WAIT;
      judge_q       <= J_NONE;
      judge_valid_q <= 1'b0;
      hit_q         <= 1'b0;
      consume_q     <= 1'b0;
      score_q       <= '0;
      combo_q       <= '0;
      max_combo_q   <= '0;
    end else begin
      judge_q       <= J_NONE;
      judge_valid_q <= 1'b0;
      hit_q         <= 1'b0;
      consume_q     <= 1'b0;
      case (state_q)
        S_WAIT: begin
          // An advancing stream is looked at again once the new note has settled
          if (note_valid && (note_lane != LW'(LANE_REST)) && !note_advance) begin
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (!note_valid) begin
            state_q <= S_WAIT;
          end else if (press_grade != J_NONE) begin
            judge_valid_q <= 1'b1;
            judge_q       <= press_grade;
            if (press_grade == J_MISS) begin
              combo_q <= '0;
            end else begin
              hit_q       <= 1'b1;
              consume_q   <= 1'b1;
              score_q     <= score_d;
              combo_q     <= combo_d;
              max_combo_q <= max_combo_d;
            end
            // A press landing with the advance still counts; the advance is honoured too
            state_q <= note_advance ? S_WAIT : S_DONE;
          end else if (note_advance) begin
            // Note left the slot unplayed: late miss
            judge_valid_q <= 1'b1;
            judge_q       <= J_MISS;
            combo_q       <= '0;
            state_q       <= S_WAIT;
          end
        end
        S_DONE: begin
          if (note_advance || !note_valid) begin
            state_q <= S_WAIT;
          end
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign judge_valid = judge_valid_q;
  assign judge       = judge_q;
  assign hit         = hit_q;
  assign consume     = consume_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_combo_q;

endmodule

// File: tb/tb_note_judge.sv
// tb/tb_note_judge.sv - scoreboard bench for note_judge
module tb_note_judge;
  import note_judge_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] key = '0;
  logic       note_valid = 1'b0;
  logic [1:0] note_lane = '0;
  logic [8:0] note_x = '0;
  logic       note_advance = 1'b0;
  logic       judge_valid;
  logic [1:0] judge;
  logic       hit;
  logic       consume;
  logic [7:0] score;
  logic [7:0] combo;
  logic [7:0] max_combo;

  note_judge dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .key          (key),
    .note_valid   (note_valid),
    .note_lane    (note_lane),
    .note_x       (note_x),
    .note_advance (note_advance),
    .judge_valid  (judge_valid),
    .judge        (judge),
    .hit          (hit),
    .consume      (consume),
    .score        (score),
    .combo        (combo),
    .max_combo    (max_combo)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [1:0] j;
    logic       h;
    int         s;
    int         c;
    int         m;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_score = 0;
  int   m_combo = 0;
  int   m_max = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic [1:0] grade(input int lane, input int x, input logic [2:0] mask);
    logic [2:0] want;
    want = (lane >= 1 && lane <= 3) ? 3'(1 << (lane - 1)) : 3'b000;
    if (mask == 3'b000 || x > 10) return 2'd0;
    if ((mask & ~want) != 3'b000) return 2'd3;
    if (x <= 4) return 2'd1;
    return 2'd2;
  endfunction

  task automatic push(input logic [1:0] g);
    exp_t e;
    if (g == 2'd1 || g == 2'd2) begin
      m_score = m_score + ((g == 2'd1) ? 3 : 1);
      if (m_score > 255) m_score = 255;
      if (m_combo < 255) m_combo = m_combo + 1;
      if (m_combo > m_max) m_max = m_combo;
    end else begin
      m_combo = 0;
    end
    e.j = g;
    e.h = (g != 2'd3);
    e.s = m_score;
    e.c = m_combo;
    e.m = m_max;
    sbq.push_back(e);
  endtask

  // One note through the slot: arm, optional press (mask 0 = none), optional hold/second press, advance
  task automatic play(input int lane, input int x, input logic [2:0] mask,
                      input int hold, input bit second, input bit adv_same);
    logic [1:0] g;
    note_valid = 1'b1;
    note_lane  = 2'(lane);
    note_x     = 9'(x);
    key        = '0;
    tick();
    tick();
    g = (lane == 0) ? 2'd0 : grade(lane, x, mask);
    key = mask;
    if (adv_same) note_advance = 1'b1;
    if (g != 2'd0) push(g);
    tick();
    note_advance = 1'b0;
    repeat (hold) tick();
    if (second) begin
      key = '0;
      tick();
      key = mask;
      tick();
    end
    key = '0;
    tick();
    if (!adv_same) begin
      note_advance = 1'b1;
      if (g == 2'd0 && lane != 0) push(2'd3);
      tick();
      note_advance = 1'b0;
    end
    note_valid = 1'b0;
    note_lane  = '0;
    tick();
  endtask

  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (judge_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_judge", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("judge", judge, mon_e.j);
          chk("hit", hit, mon_e.h);
          chk("consume", consume, mon_e.h);
          chk("score", score, mon_e.s);
          chk("combo", combo, mon_e.c);
          chk("max_combo", max_combo, mon_e.m);
        end
      end else begin
        chk("idle_outputs", {judge, hit, consume}, 32'd0);
      end
    end
  end

  initial begin
    repeat (2) tick();
    chk("rst_judge_valid", judge_valid, 0);
    chk("rst_judge", judge, 0);
    chk("rst_hit", hit, 0);
    chk("rst_consume", consume, 0);
    chk("rst_score", score, 0);
    chk("rst_combo", combo, 0);
    chk("rst_max_combo", max_combo, 0);
    reset = 1'b0;
    tick();

    play(2, 3, 3'b010, 0, 0, 0);
    play(1, 8, 3'b001, 0, 1, 0);
    play(1, 5, 3'b101, 0, 0, 0);
    play(1, 20, 3'b001, 0, 0, 0);
    play(2, 11, 3'b010, 0, 0, 0);
    play(0, 3, 3'b001, 0, 0, 0);
    play(3, 0, 3'b100, 0, 0, 0);
    play(1, 4, 3'b001, 0, 0, 0);
    play(2, 10, 3'b010, 0, 0, 0);
    play(3, 4, 3'b100, 0, 0, 0);
    play(2, 5, 3'b000, 0, 0, 0);
    chk("max_combo_keep", max_combo, 4);
    chk("combo_after_late_miss", combo, 0);
    play(1, 2, 3'b001, 0, 0, 1);

    for (int i = 0; i < 79; i++) begin
      play(1 + (i % 3), i % 5, 3'(1 << (i % 3)), 0, 0, 0);
    end
    chk("score_preset", score, 254);
    play(2, 1, 3'b010, 100, 0, 0);
    chk("score_sat", score, 255);
    play(3, 7, 3'b100, 0, 0, 0);
    chk("score_sat_hold", score, 255);
    repeat (3) tick();
    chk("sb_drain", sbq.size(), 0);

    note_valid = 1'b1;
    note_lane  = 2'd2;
    note_x     = 9'd3;
    tick();
    tick();
    key   = 3'b010;
    reset = 1'b1;
    tick();
    tick();
    chk("mid_rst_judge_valid", judge_valid, 0);
    chk("mid_rst_score", score, 0);
    chk("mid_rst_combo", combo, 0);
    chk("mid_rst_max_combo", max_combo, 0);
    sbq.delete();
    m_score = 0;
    m_combo = 0;
    m_max   = 0;
    reset = 1'b0;
    repeat (5) tick();
    chk("post_rst_score", score, 0);
    key        = '0;
    note_valid = 1'b0;
    note_lane  = '0;
    tick();
    play(2, 3, 3'b010, 0, 0, 0);
    repeat (3) tick();
    chk("final_score", score, 3);
    chk("final_drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
